// File: rtl/mmio_wr_queue.sv
// Circular MMIO write queue: host writes enqueue words, host reads dequeue the
// oldest word one cycle later; occupancy and sticky error flags feed a status CSR.
module mmio_wr_queue #(
  parameter  int unsigned DATA_W = 64,
  parameter  int unsigned DEPTH  = 8,
  localparam int unsigned PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic [PTR_W:0]    count,
  output logic              overflow,
  output logic              underflow,
  input  logic              clr_err
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q,    wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q,    rd_ptr_d;
  logic [PTR_W:0]    count_q,     count_d;
  logic [DATA_W-1:0] rd_data_q,   rd_data_d;
  logic              rd_valid_q,  rd_valid_d;
  logic              overflow_q,  overflow_d;
  logic              underflow_q, underflow_d;

  logic full_w, empty_w, rd_hit, wr_acc;

  assign full_w  = (count_q == FULL_CNT);
  assign empty_w = (count_q == '0);
  // A full queue still accepts a write when a real dequeue frees the head slot.
  assign rd_hit  = rd_en && !empty_w;
  assign wr_acc  = wr_en && (!full_w || rd_hit);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = rd_en;
    overflow_d  = clr_err ? 1'b0 : overflow_q;
    underflow_d = clr_err ? 1'b0 : underflow_q;

    if (rd_en) begin
      if (rd_hit) begin
        rd_data_d = mem[rd_ptr_q];
        rd_ptr_d  = rd_ptr_q + PTR_W'(1);
      end else begin
        rd_data_d   = '0;
        underflow_d = 1'b1;
      end
    end

    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else if (wr_en) begin
      overflow_d = 1'b1;
    end

    case ({wr_acc, rd_hit})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately not reset; entries are unobservable until rewritten.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign full      = full_w;
  assign empty     = empty_w;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule
